// File: rtl/ad7124_pkg.sv
// ad7124_pkg: AD7124 command constants and sequencer state type shared by the TC and RTD schedulers
//   AD7124_CMD_RD_DATA  command byte that reads the conversion data register
//   ad7124_state_t      scan sequencer states
package ad7124_pkg;

    localparam logic [7:0] AD7124_CMD_RD_DATA = 8'h42;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        REQ,
        WAIT,
        STORE,
        DONE
    } ad7124_state_t;

endpackage

// File: rtl/ad7124_next_ch.sv
// ad7124_next_ch: combinational search for the lowest enabled channel at or above a pointer
//   mask   in   N    enabled-channel mask
//   ptr    in   PW   first index to consider (may equal N, meaning nothing left)
//   found  out  1    an enabled channel >= ptr exists
//   idx    out  IW   lowest such channel index (0 when not found)
module ad7124_next_ch #(
    parameter int N  = 8,
    parameter int IW = $clog2(N),
    parameter int PW = $clog2(N + 1)
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest qualifying index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (mask[i] && PW'(i) >= ptr) begin
                found = 1'b1;
                idx   = IW'(i);
            end
    end

endmodule

// File: rtl/ad7124_tc_scan_sched.sv
// ad7124_tc_scan_sched: walks the enabled TC ADC channels and issues one RD_DATA transfer per channel
//   aclk, aresetn      clock, asynchronous active-low reset
//   ctrl_start/stop    scan start pulse, graceful stop pulse
//   ctrl_continuous    restart automatically after each completed scan
//   ch_enable          channel mask, latched at each scan start
//   spi_req/cs_sel/cmd request to the shared SPI master (held until spi_ack)
//   spi_ack/done/rdata SPI master handshake and received word
//   result_valid/ch/data  one-cycle result pulse
//   scan_done          one-cycle end-of-scan pulse
//   busy               sequencer not idle
//   err_timeout        sticky per-channel timeout flags, cleared on start
module ad7124_tc_scan_sched
    import ad7124_pkg::*;
#(
    parameter int C_N_TC_CHANNEL   = 8,
    parameter int C_DATA_WIDTH     = 24,
    parameter int C_TIMEOUT_CYCLES = 65535,
    parameter int IW               = $clog2(C_N_TC_CHANNEL)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      ctrl_start,
    input  logic                      ctrl_stop,
    input  logic                      ctrl_continuous,
    input  logic [C_N_TC_CHANNEL-1:0] ch_enable,
    output logic                      spi_req,
    output logic [IW-1:0]             spi_cs_sel,
    output logic [7:0]                spi_cmd,
    input  logic                      spi_ack,
    input  logic                      spi_done,
    input  logic [C_DATA_WIDTH-1:0]   spi_rdata,
    output logic                      result_valid,
    output logic [IW-1:0]             result_ch,
    output logic [C_DATA_WIDTH-1:0]   result_data,
    output logic                      scan_done,
    output logic                      busy,
    output logic [C_N_TC_CHANNEL-1:0] err_timeout
);

    // Pointer needs one extra code so "past the last channel" ends the scan instead of wrapping.
    localparam int          PW   = $clog2(C_N_TC_CHANNEL + 1);
    localparam logic [15:0] TMAX = 16'(C_TIMEOUT_CYCLES - 1);

    ad7124_state_t             state;
    logic [C_N_TC_CHANNEL-1:0] mask;
    logic [PW-1:0]             ptr;
    logic [15:0]               timer;
    logic                      stop_pend;
    logic                      found;
    logic [IW-1:0]             idx;
    logic [PW-1:0]             next_ptr;

    assign spi_cmd  = AD7124_CMD_RD_DATA;
    assign busy     = state != IDLE;
    assign next_ptr = PW'(spi_cs_sel) + PW'(1);

    ad7124_next_ch #(.N(C_N_TC_CHANNEL), .IW(IW), .PW(PW)) u_next_ch (
        .mask  (mask),
        .ptr   (ptr),
        .found (found),
        .idx   (idx)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            mask         <= '0;
            ptr          <= '0;
            timer        <= '0;
            stop_pend    <= 1'b0;
            spi_req      <= 1'b0;
            spi_cs_sel   <= '0;
            result_valid <= 1'b0;
            result_ch    <= '0;
            result_data  <= '0;
            scan_done    <= 1'b0;
            err_timeout  <= '0;
        end else begin
            result_valid <= 1'b0;
            scan_done    <= 1'b0;
            if (ctrl_stop && state != IDLE)
                stop_pend <= 1'b1;
            case (state)
                IDLE: begin
                    stop_pend <= 1'b0;
                    if (ctrl_start && |ch_enable) begin
                        mask        <= ch_enable;
                        err_timeout <= '0;
                        ptr         <= '0;
                        state       <= SEL;
                    end
                end
                // A pending stop is honoured between transfers, never mid-transfer.
                SEL: begin
                    if (stop_pend || ctrl_stop)
                        state <= IDLE;
                    else if (found) begin
                        spi_cs_sel <= idx;
                        spi_req    <= 1'b1;
                        state      <= REQ;
                    end else begin
                        scan_done <= 1'b1;
                        state     <= DONE;
                    end
                end
                REQ: begin
                    if (spi_ack) begin
                        spi_req <= 1'b0;
                        timer   <= '0;
                        state   <= WAIT;
                    end
                end
                // spi_done is tested first so it wins over a simultaneous timeout.
                WAIT: begin
                    if (spi_done) begin
                        result_valid <= 1'b1;
                        result_ch    <= spi_cs_sel;
                        result_data  <= spi_rdata;
                        state        <= STORE;
                    end else if (timer == TMAX) begin
                        err_timeout[spi_cs_sel] <= 1'b1;
                        ptr                     <= next_ptr;
                        state                   <= SEL;
                    end else
                        timer <= timer + 16'd1;
                end
                STORE: begin
                    ptr   <= next_ptr;
                    state <= SEL;
                end
                DONE: begin
                    if (ctrl_continuous && !stop_pend && !ctrl_stop && |ch_enable) begin
                        mask  <= ch_enable;
                        ptr   <= '0;
                        state <= SEL;
                    end else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad7124_tc_scan_sched.sv
// tb_ad7124_tc_scan_sched: directed bench for the TC scan scheduler with a scripted SPI master
module tb_ad7124_tc_scan_sched;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        ctrl_start, ctrl_stop, ctrl_continuous;
    logic [7:0]  ch_enable;
    logic        spi_req;
    logic [2:0]  spi_cs_sel;
    logic [7:0]  spi_cmd;
    logic        spi_ack, spi_done;
    logic [23:0] spi_rdata;
    logic        result_valid;
    logic [2:0]  result_ch;
    logic [23:0] result_data;
    logic        scan_done, busy;
    logic [7:0]  err_timeout;

    int n_chk = 0;
    int n_err = 0;
    int ack_dly = 2;
    int done_dly = 40;
    int cyc = 0;
    int ack_cyc = 0;
    int err_cyc = 0;
    int scan_cnt = 0;
    int req_cnt = 0;
    logic        req_q = 1'b0;
    logic [7:0]  err_q = 8'h0;
    int          res_ch[$];
    logic [23:0] res_dat[$];

    ad7124_tc_scan_sched #(
        .C_N_TC_CHANNEL   (8),
        .C_DATA_WIDTH     (24),
        .C_TIMEOUT_CYCLES (100)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .ctrl_start      (ctrl_start),
        .ctrl_stop       (ctrl_stop),
        .ctrl_continuous (ctrl_continuous),
        .ch_enable       (ch_enable),
        .spi_req         (spi_req),
        .spi_cs_sel      (spi_cs_sel),
        .spi_cmd         (spi_cmd),
        .spi_ack         (spi_ack),
        .spi_done        (spi_done),
        .spi_rdata       (spi_rdata),
        .result_valid    (result_valid),
        .result_ch       (result_ch),
        .result_data     (result_data),
        .scan_done       (scan_done),
        .busy            (busy),
        .err_timeout     (err_timeout)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Master's data word: tags each channel so results can be told apart.
    function automatic logic [23:0] master_data(input logic [2:0] ch);
        return {8'h5A, 5'h0, ch, 8'hC3};
    endfunction

    always @(negedge aclk) begin
        if (result_valid) begin
            res_ch.push_back(int'(result_ch));
            res_dat.push_back(result_data);
        end
        if (scan_done) scan_cnt++;
        if (spi_req && !req_q) req_cnt++;
        if (err_timeout != 8'h0 && err_q == 8'h0) err_cyc = cyc;
        req_q = spi_req;
        err_q = err_timeout;
    end

    // Scripted SPI master: ack after ack_dly cycles, done after done_dly (0 = never).
    initial begin
        spi_ack = 1'b0;
        spi_done = 1'b0;
        spi_rdata = '0;
        forever begin
            @(negedge aclk);
            if (spi_req) begin
                repeat (ack_dly - 1) @(negedge aclk);
                spi_ack = 1'b1;
                ack_cyc = cyc;
                @(negedge aclk);
                spi_ack = 1'b0;
                if (done_dly > 0) begin
                    repeat (done_dly - 1) @(negedge aclk);
                    spi_done = 1'b1;
                    spi_rdata = master_data(spi_cs_sel);
                    @(negedge aclk);
                    spi_done = 1'b0;
                end
            end
        end
    end

    task automatic pulse_start(input logic [7:0] m);
        ch_enable = m;
        ctrl_start = 1'b1;
        @(negedge aclk);
        ctrl_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k = 0;
        while (busy && k < lim) begin
            @(negedge aclk);
            k++;
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        int b, s, r;
        aresetn = 1'b0;
        ctrl_start = 1'b0;
        ctrl_stop = 1'b0;
        ctrl_continuous = 1'b0;
        ch_enable = 8'h0;
        repeat (3) @(negedge aclk);
        chk("rst_busy", busy, 0);
        chk("rst_req", spi_req, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_cs", spi_cs_sel, 0);
        chk("cmd", spi_cmd, 8'h42);
        aresetn = 1'b1;
        @(negedge aclk);

        // 1: mask A5 -> channels 0,2,5,7 in order, one scan_done
        b = res_ch.size(); s = scan_cnt;
        pulse_start(8'hA5);
        chk("t1_busy", busy, 1);
        wait_idle("t1_idle", 1000);
        chk("t1_count", res_ch.size() - b, 4);
        if (res_ch.size() - b == 4) begin
            chk("t1_ch0", res_ch[b],   0);
            chk("t1_ch1", res_ch[b+1], 2);
            chk("t1_ch2", res_ch[b+2], 5);
            chk("t1_ch3", res_ch[b+3], 7);
            chk("t1_d0", res_dat[b],   24'h5A00C3);
            chk("t1_d1", res_dat[b+1], 24'h5A02C3);
            chk("t1_d2", res_dat[b+2], 24'h5A05C3);
            chk("t1_d3", res_dat[b+3], 24'h5A07C3);
        end
        chk("t1_scan_done", scan_cnt - s, 1);
        chk("t1_err", err_timeout, 0);

        // 2: mask 0 -> nothing happens
        r = req_cnt; s = scan_cnt;
        pulse_start(8'h00);
        chk("t2_busy", busy, 0);
        repeat (5) @(negedge aclk);
        chk("t2_busy_late", busy, 0);
        chk("t2_req", req_cnt - r, 0);
        chk("t2_scan_done", scan_cnt - s, 0);

        // 3: single channel, master never completes -> timeout after 100 WAIT cycles
        done_dly = 0;
        b = res_ch.size(); s = scan_cnt;
        pulse_start(8'h01);
        wait_idle("t3_idle", 400);
        chk("t3_err", err_timeout, 8'h01);
        chk("t3_err_time", err_cyc - ack_cyc, 101);
        chk("t3_no_result", res_ch.size() - b, 0);
        chk("t3_scan_done", scan_cnt - s, 1);

        // 4: continuous scan, stop during WAIT of ch1 -> ch1 result, then IDLE
        done_dly = 40;
        ctrl_continuous = 1'b1;
        b = res_ch.size(); s = scan_cnt;
        pulse_start(8'h03);
        chk("t4_err_clear", err_timeout, 0);
        begin
            int k = 0;
            while (!(spi_req && spi_cs_sel == 3'd1) && k < 300) begin
                @(negedge aclk);
                k++;
            end
            chk("t4_req_ch1", spi_req, 1);
            k = 0;
            while (spi_req && k < 50) begin
                @(negedge aclk);
                k++;
            end
        end
        repeat (5) @(negedge aclk);
        ctrl_stop = 1'b1;
        @(negedge aclk);
        ctrl_stop = 1'b0;
        wait_idle("t4_idle", 300);
        chk("t4_count", res_ch.size() - b, 2);
        if (res_ch.size() - b == 2) chk("t4_last_ch", res_ch[b+1], 1);
        r = req_cnt;
        repeat (100) @(negedge aclk);
        chk("t4_scan_done", scan_cnt - s, 0);
        chk("t4_no_restart", req_cnt - r, 0);
        chk("t4_busy_late", busy, 0);
        ctrl_continuous = 1'b0;

        // 5: async reset during WAIT, then rescan from ch0
        b = res_ch.size();
        pulse_start(8'h06);
        begin
            int k = 0;
            while (!spi_ack && k < 100) begin
                @(negedge aclk);
                k++;
            end
        end
        repeat (10) @(negedge aclk);
        chk("t5_busy_before", busy, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("t5_rst_req", spi_req, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valid", result_valid, 0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (60) @(negedge aclk);
        chk("t5_no_result", res_ch.size() - b, 0);
        pulse_start(8'h05);
        wait_idle("t5_idle", 400);
        chk("t5_count", res_ch.size() - b, 2);
        if (res_ch.size() - b == 2) begin
            chk("t5_first_ch", res_ch[b], 0);
            chk("t5_second_ch", res_ch[b+1], 2);
        end

        // 6: spi_done on the same cycle the timer hits its limit -> done wins
        done_dly = 100;
        b = res_ch.size();
        pulse_start(8'h01);
        wait_idle("t6_idle", 400);
        chk("t6_count", res_ch.size() - b, 1);
        if (res_ch.size() - b == 1) chk("t6_data", res_dat[b], 24'h5A00C3);
        chk("t6_err", err_timeout, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
